// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants
// and the majority-vote helper used for bit recovery.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } rx_state_e;

   localparam int unsigned OVERSAMPLE = 16;

   localparam logic [3:0] SC_SAMPLE_A = 4'd7;
   localparam logic [3:0] SC_SAMPLE_B = 4'd8;
   localparam logic [3:0] SC_SAMPLE_C = 4'd9;
   localparam logic [3:0] SC_BIT_END  = 4'd15;

   localparam int unsigned DATA_BITS    = 8;
   localparam logic [2:0]  LAST_BIT_IDX = 3'(DATA_BITS - 1);

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side UART bundle: serial line in, holding-register handshake and
// error pulses out. slave = receiver, master = line driver / byte consumer.
interface uart_rx_if;
   logic       uart_rx_i;
   logic [7:0] uart_dat_o;
   logic       uart_valid_o;
   logic       uart_rd_i;
   logic       uart_frame_err_o;
   logic       uart_overrun_o;

   modport slave (
      input  uart_rx_i,
      input  uart_rd_i,
      output uart_dat_o,
      output uart_valid_o,
      output uart_frame_err_o,
      output uart_overrun_o
   );

   modport master (
      output uart_rx_i,
      output uart_rd_i,
      input  uart_dat_o,
      input  uart_valid_o,
      input  uart_frame_err_o,
      input  uart_overrun_o
   );
endinterface

// File: rtl/uart_baud_tick.sv
// Fractional-rate tick generator: one-cycle pulse at an average of RATE per
// second from a CLK_HZ clock, with no cumulative drift.
module uart_baud_tick #(
   parameter int unsigned CLK_HZ = 100_000_000,
   parameter int unsigned RATE   = 1_843_200
) (
   input  logic sys_clk_i,
   input  logic sys_rst_i,
   output logic tick_o
);

   localparam logic [32:0] INC     = 33'(RATE);
   localparam logic [32:0] MODULUS = 33'(CLK_HZ);

   logic [31:0] acc_q;
   logic [31:0] acc_d;
   logic        tick_q;
   logic        tick_d;
   logic [32:0] sum_s;

   // Accumulate and wrap; the remainder carries into the next period.
   always_comb begin
      sum_s = {1'b0, acc_q} + INC;
      if (sum_s >= MODULUS) begin
         acc_d  = 32'(sum_s - MODULUS);
         tick_d = 1'b1;
      end else begin
         acc_d  = sum_s[31:0];
         tick_d = 1'b0;
      end
   end

   // Accumulator and tick register.
   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         acc_q  <= 32'd0;
         tick_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         tick_q <= tick_d;
      end
   end

   assign tick_o = tick_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, 2-of-3 majority bit recovery and a
// one-entry holding register with overrun and framing-error pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ = 100_000_000,
   parameter int unsigned BAUD   = 115200
) (
   input  logic     sys_clk_i,
   input  logic     sys_rst_i,
   uart_rx_if.slave rx_if
);

   logic       tick_s;
   logic [1:0] sync_q;
   logic       rx_s;

   rx_state_e  state_q, state_d;
   logic [3:0] sc_q, sc_d;
   logic [2:0] bit_idx_q, bit_idx_d;
   logic [7:0] shift_q, shift_d;
   logic       samp_a_q, samp_a_d;
   logic       samp_b_q, samp_b_d;
   logic [7:0] dat_q, dat_d;
   logic       valid_q, valid_d;
   logic       frame_err_q, frame_err_d;
   logic       overrun_q, overrun_d;

   logic       bv_s;
   logic       running_s;
   logic       good_stop_s;

   uart_baud_tick #(
      .CLK_HZ (CLK_HZ),
      .RATE   (BAUD * OVERSAMPLE)
   ) u_baud_tick (
      .sys_clk_i (sys_clk_i),
      .sys_rst_i (sys_rst_i),
      .tick_o    (tick_s)
   );

   // Two-flop synchronizer; idles high so reset never looks like a start bit.
   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], rx_if.uart_rx_i};
      end
   end

   assign rx_s = sync_q[1];

   // Frame FSM, sampling and holding-register next state.
   always_comb begin
      state_d     = state_q;
      sc_d        = sc_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      samp_a_d    = samp_a_q;
      samp_b_d    = samp_b_q;
      dat_d       = dat_q;
      valid_d     = valid_q;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
      good_stop_s = 1'b0;

      bv_s      = maj3(samp_a_q, samp_b_q, rx_s);
      running_s = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);

      if (tick_s && running_s) begin
         sc_d = sc_q + 4'd1;
         if (sc_q == SC_SAMPLE_A) begin
            samp_a_d = rx_s;
         end else if (sc_q == SC_SAMPLE_B) begin
            samp_b_d = rx_s;
         end else begin
            samp_a_d = samp_a_q;
         end
      end else begin
         sc_d = sc_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (tick_s && !rx_s) begin
               sc_d    = 4'd0;
               state_d = ST_START;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            if (tick_s && (sc_q == SC_SAMPLE_C) && bv_s) begin
               state_d = ST_IDLE;
            end else if (tick_s && (sc_q == SC_BIT_END)) begin
               bit_idx_d = 3'd0;
               state_d   = ST_DATA;
            end else begin
               state_d = ST_START;
            end
         end
         ST_DATA: begin
            if (tick_s && (sc_q == SC_SAMPLE_C)) begin
               shift_d = {bv_s, shift_q[7:1]};
            end else if (tick_s && (sc_q == SC_BIT_END)) begin
               if (bit_idx_q == LAST_BIT_IDX) begin
                  state_d = ST_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               shift_d = shift_q;
            end
         end
         ST_STOP: begin
            // Leave at mid-stop so the next start edge is caught without loss.
            if (tick_s && (sc_q == SC_SAMPLE_C)) begin
               if (bv_s) begin
                  good_stop_s = 1'b1;
                  state_d     = ST_IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = ST_BREAK;
               end
            end else begin
               state_d = ST_STOP;
            end
         end
         ST_BREAK: begin
            if (tick_s && rx_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_BREAK;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A read in the load cycle frees the register for the new byte.
      if (good_stop_s) begin
         if (!valid_q || rx_if.uart_rd_i) begin
            dat_d   = shift_q;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (rx_if.uart_rd_i && valid_q) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // Receiver state and output registers.
   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         state_q     <= ST_IDLE;
         sc_q        <= 4'd0;
         bit_idx_q   <= 3'd0;
         shift_q     <= 8'd0;
         samp_a_q    <= 1'b1;
         samp_b_q    <= 1'b1;
         dat_q       <= 8'd0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sc_q        <= sc_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         samp_a_q    <= samp_a_d;
         samp_b_q    <= samp_b_d;
         dat_q       <= dat_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign rx_if.uart_dat_o       = dat_q;
   assign rx_if.uart_valid_o     = valid_q;
   assign rx_if.uart_frame_err_o = frame_err_q;
   assign rx_if.uart_overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a serial line driver with adjustable bit
// rate, a byte scoreboard queue and a pulse/edge monitor.
module tb_uart_rx;

   // Clock chosen so one oversample tick is exactly 9 cycles (144 per bit).
   localparam int unsigned CLK_HZ   = 16_588_800;
   localparam int unsigned BAUD     = 115200;
   localparam int          BIT_CYC  = 144;
   localparam int          TICK_CYC = 9;
   localparam int          FRAME_CYC = 10 * BIT_CYC;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   uart_rx_if bus ();

   uart_rx #(
      .CLK_HZ (CLK_HZ),
      .BAUD   (BAUD)
   ) dut (
      .sys_clk_i (clk),
      .sys_rst_i (rst),
      .rx_if     (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] exp_q[$];

   int   cyc = 0;
   logic valid_prev = 1'b0;
   int   valid_rises = 0;
   int   valid_rise_cyc = 0;
   int   fe_cnt = 0;
   int   ov_cnt = 0;
   int   ov_last_cyc = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

   always @(negedge clk) begin
      if (bus.uart_valid_o && !valid_prev) begin
         valid_rises++;
         valid_rise_cyc = cyc;
      end
      valid_prev = bus.uart_valid_o;
      if (bus.uart_frame_err_o) fe_cnt++;
      if (bus.uart_overrun_o) begin
         ov_cnt++;
         ov_last_cyc = cyc;
      end
   end

   task automatic send_frame(input logic [7:0] d, input logic stop, input real factor);
      logic [9:0] bits;
      real        bit_len;
      real        t_acc;
      int         done;
      bits    = {stop, d, 1'b0};
      bit_len = real'(BIT_CYC) / factor;
      t_acc   = 0.0;
      done    = 0;
      for (int i = 0; i < 10; i++) begin
         bus.uart_rx_i = bits[i];
         t_acc += bit_len;
         while (done < int'(t_acc)) begin
            @(negedge clk);
            done++;
         end
      end
   endtask

   task automatic idle_bits(input int n);
      bus.uart_rx_i = 1'b1;
      repeat (n * BIT_CYC) @(negedge clk);
   endtask

   task automatic align_tick();
      @(negedge clk);
      while ((cyc % TICK_CYC) != 0) @(negedge clk);
   endtask

   task automatic expect_byte(input string tag);
      int         n;
      logic [7:0] e;
      n = 0;
      while (!bus.uart_valid_o && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check_eq({tag, "_valid"}, 32'(bus.uart_valid_o), 32'd1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      check_eq({tag, "_data"}, 32'(bus.uart_dat_o), 32'(e));
      bus.uart_rd_i = 1'b1;
      @(negedge clk);
      bus.uart_rd_i = 1'b0;
      check_eq({tag, "_rd_clear"}, 32'(bus.uart_valid_o), 32'd0);
   endtask

   initial begin
      #20_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int   start;
      int   lat;
      int   rises0;
      int   fe0;
      int   ov0;
      int   d_off;
      real  facs[2];
      logic [7:0] tol_b[3];

      facs  = '{1.03, 0.97};
      tol_b = '{8'h00, 8'hFF, 8'h5A};
      d_off = 0;

      bus.uart_rx_i = 1'b1;
      bus.uart_rd_i = 1'b0;
      rst = 1'b1;
      repeat (5) @(negedge clk);
      check_eq("rst_dat", 32'(bus.uart_dat_o), 32'd0);
      check_eq("rst_valid", 32'(bus.uart_valid_o), 32'd0);
      check_eq("rst_frame_err", 32'(bus.uart_frame_err_o), 32'd0);
      check_eq("rst_overrun", 32'(bus.uart_overrun_o), 32'd0);
      rst = 1'b0;
      idle_bits(1);

      // Basic byte plus latency from start edge to valid (~9.6 bits).
      exp_q.push_back(8'hA5);
      align_tick();
      start  = cyc;
      rises0 = valid_rises;
      send_frame(8'hA5, 1'b1, 1.0);
      idle_bits(1);
      check_eq("a5_one_valid_rise", 32'(valid_rises - rises0), 32'd1);
      lat = valid_rise_cyc - start;
      $display("info: valid latency %0d cycles", lat);
      check_eq("a5_latency_window", 32'((lat >= 1375) && (lat <= 1405)), 32'd1);
      expect_byte("a5");

      // Short low glitch must not start a frame.
      rises0 = valid_rises;
      fe0    = fe_cnt;
      bus.uart_rx_i = 1'b0;
      repeat (33) @(negedge clk);
      idle_bits(2);
      check_eq("glitch_no_valid", 32'(valid_rises - rises0), 32'd0);
      check_eq("glitch_no_frame_err", 32'(fe_cnt - fe0), 32'd0);
      exp_q.push_back(8'h3C);
      send_frame(8'h3C, 1'b1, 1.0);
      idle_bits(1);
      expect_byte("after_glitch_3c");

      // Bad stop bit followed by a held-low line.
      rises0 = valid_rises;
      fe0    = fe_cnt;
      send_frame(8'h55, 1'b0, 1.0);
      bus.uart_rx_i = 1'b0;
      repeat (2 * BIT_CYC) @(negedge clk);
      idle_bits(2);
      check_eq("ferr_one_pulse", 32'(fe_cnt - fe0), 32'd1);
      check_eq("ferr_no_valid", 32'(valid_rises - rises0), 32'd0);
      check_eq("ferr_valid_low", 32'(bus.uart_valid_o), 32'd0);
      exp_q.push_back(8'h81);
      send_frame(8'h81, 1'b1, 1.0);
      idle_bits(1);
      expect_byte("after_ferr_81");

      // Back-to-back with no read: second byte dropped.
      ov0 = ov_cnt;
      exp_q.push_back(8'h11);
      align_tick();
      start = cyc;
      send_frame(8'h11, 1'b1, 1.0);
      send_frame(8'h22, 1'b1, 1.0);
      idle_bits(1);
      check_eq("ovr_one_pulse", 32'(ov_cnt - ov0), 32'd1);
      d_off = ov_last_cyc - (start + FRAME_CYC);
      expect_byte("ovr_keep_11");

      // Same again with a read exactly in the second load cycle.
      ov0 = ov_cnt;
      exp_q.push_back(8'h22);
      align_tick();
      start = cyc;
      fork
         begin
            send_frame(8'h11, 1'b1, 1.0);
            send_frame(8'h22, 1'b1, 1.0);
         end
         begin
            int n;
            n = 0;
            while ((cyc != start + FRAME_CYC + d_off - 1) && n < 4000) begin
               @(negedge clk);
               n++;
            end
            bus.uart_rd_i = 1'b1;
            @(negedge clk);
            bus.uart_rd_i = 1'b0;
         end
      join
      idle_bits(1);
      check_eq("simul_rd_no_overrun", 32'(ov_cnt - ov0), 32'd0);
      expect_byte("simul_rd_22");

      // Baud mismatch tolerance.
      foreach (facs[f]) begin
         foreach (tol_b[b]) begin
            exp_q.push_back(tol_b[b]);
            send_frame(tol_b[b], 1'b1, facs[f]);
            idle_bits(2);
            expect_byte($sformatf("tol%0d_%02h", f, tol_b[b]));
         end
      end

      // Reset in the middle of a frame with a byte still pending.
      send_frame(8'h33, 1'b1, 1.0);
      idle_bits(1);
      check_eq("pre_rst_valid", 32'(bus.uart_valid_o), 32'd1);
      align_tick();
      fork
         send_frame(8'hF0, 1'b1, 1.0);
         begin
            repeat (5 * BIT_CYC + BIT_CYC / 2) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check_eq("midrst_dat", 32'(bus.uart_dat_o), 32'd0);
            check_eq("midrst_valid", 32'(bus.uart_valid_o), 32'd0);
            check_eq("midrst_frame_err", 32'(bus.uart_frame_err_o), 32'd0);
            check_eq("midrst_overrun", 32'(bus.uart_overrun_o), 32'd0);
         end
      join
      rises0 = valid_rises;
      fe0    = fe_cnt;
      idle_bits(2);
      check_eq("midrst_partial_lost", 32'(valid_rises - rises0), 32'd0);
      check_eq("midrst_no_frame_err", 32'(fe_cnt - fe0), 32'd0);
      exp_q.push_back(8'h0F);
      send_frame(8'h0F, 1'b1, 1.0);
      idle_bits(1);
      expect_byte("after_rst_0f");

      check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
